branch_predictor: RTL and testbench

Parametrised fetch-side branch prediction and EX-side misprediction detection unit for the 5-stage MIPS core.
- IF stage: direct-mapped BTB with 2-bit saturating direction counters, plus a return-address stack (RAS). Produces a registered prediction one cycle after lookup.
- EX stage: the existing branch-resolution logic supplies actual outcome and target. This block updates its tables and raises a registered mispredict/redirect pulse.

---
 rtl/branch_predictor_if.sv | 33 +++
 rtl/branch_predictor.sv | 210 +++++++++++++++++++++
 tb/tb_branch_predictor.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch/execute-side connection to the branch predictor: IF lookup, EX resolve,
// registered prediction and mispredict redirect.
interface branch_predictor_if;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [3:0]  ex_type;
    logic        ex_rs_is_ra;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;

    modport master (
        output if_valid, if_pc,
        output ex_valid, ex_pc, ex_type, ex_rs_is_ra, ex_taken, ex_target,
        output ex_pred_taken, ex_pred_target,
        input  pred_valid, pred_taken, pred_target, mispredict, redirect_pc
    );

    modport slave (
        input  if_valid, if_pc,
        input  ex_valid, ex_pc, ex_type, ex_rs_is_ra, ex_taken, ex_target,
        input  ex_pred_taken, ex_pred_target,
        output pred_valid, pred_taken, pred_target, mispredict, redirect_pc
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters and a return-address stack;
// registered IF prediction and registered EX mispredict/redirect pulse.
module branch_predictor #(
    parameter int         ENTRIES   = 64,
    parameter int         RAS_DEPTH = 8,
    parameter logic [1:0] CTR_INIT  = 2'b01
) (
    input logic               clk,
    input logic               rst,
    branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;
    localparam int RAS_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = RAS_W + 1;
    localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

    typedef enum logic [1:0] {K_COND, K_JUMP, K_CALL, K_RET} kind_e;

    typedef enum logic [3:0] {
        BT_NONE   = 4'd0,  BT_BEQ    = 4'd1,  BT_BNE    = 4'd2,  BT_BGEZ   = 4'd3,
        BT_BGTZ   = 4'd4,  BT_BLEZ   = 4'd5,  BT_BLTZ   = 4'd6,  BT_BGEZAL = 4'd7,
        BT_BLTZAL = 4'd8,  BT_J      = 4'd9,  BT_JAL    = 4'd10, BT_JR     = 4'd11,
        BT_JALR   = 4'd12
    } br_type_e;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_mem  [ENTRIES];
    logic [31:0]        tgt_mem  [ENTRIES];
    kind_e              kind_mem [ENTRIES];
    logic [1:0]         ctr_mem  [ENTRIES];

    logic [31:0]        ras_mem [RAS_DEPTH];
    logic [RAS_W-1:0]   ras_ptr;
    logic [CNT_W-1:0]   ras_cnt;

    // ---------------- IF lookup ----------------
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic             lk_taken;
    logic [RAS_W-1:0] ras_top_idx;
    logic [31:0]      lk_target;

    assign lk_idx      = bp.if_pc[IDX_W+1:2];
    assign lk_tag      = bp.if_pc[31:IDX_W+2];
    assign lk_hit      = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);
    assign lk_taken    = lk_hit && (kind_mem[lk_idx] != K_COND || ctr_mem[lk_idx][1]);
    assign ras_top_idx = ras_ptr - RAS_W'(1);
    assign lk_target   = (kind_mem[lk_idx] == K_RET && ras_cnt != '0)
                         ? ras_mem[ras_top_idx] : tgt_mem[lk_idx];

    // NOTE: every register below is written with <= so all state reads the
    // pre-edge values; this is what gives lookup read-before-write semantics.
    always_ff @(posedge clk) begin
        if (rst) begin
            bp.pred_valid  <= 1'b0;
            bp.pred_taken  <= 1'b0;
            bp.pred_target <= '0;
        end else begin
            bp.pred_valid  <= bp.if_valid;
            bp.pred_taken  <= bp.if_valid && lk_taken;
            bp.pred_target <= (bp.if_valid && lk_taken) ? lk_target : '0;
        end
    end

    // ---------------- EX classification ----------------
    logic  upd_en;
    kind_e upd_kind;
    logic  push_req;
    logic  pop_req;

    // NOTE: each output gets a default before the case so no latch is inferred.
    always_comb begin
        upd_en   = 1'b0;
        upd_kind = K_COND;
        push_req = 1'b0;
        pop_req  = 1'b0;
        if (bp.ex_valid) begin
            case (bp.ex_type)
                BT_BEQ, BT_BNE, BT_BGEZ, BT_BGTZ, BT_BLEZ, BT_BLTZ: upd_en = 1'b1;
                BT_BGEZAL, BT_BLTZAL: begin
                    upd_en   = 1'b1;
                    push_req = bp.ex_taken;
                end
                BT_J: begin
                    upd_en   = 1'b1;
                    upd_kind = K_JUMP;
                end
                BT_JAL: begin
                    upd_en   = 1'b1;
                    upd_kind = K_CALL;
                    push_req = 1'b1;
                end
                BT_JR: begin
                    upd_en   = 1'b1;
                    upd_kind = bp.ex_rs_is_ra ? K_RET : K_JUMP;
                    pop_req  = bp.ex_rs_is_ra;
                end
                BT_JALR: begin
                    upd_en   = 1'b1;
                    upd_kind = K_CALL;
                    push_req = 1'b1;
                    pop_req  = bp.ex_rs_is_ra;
                end
                default: ;
            endcase
        end
    end

    // ---------------- BTB update ----------------
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic             alloc;
    logic             hit_upd;
    logic             ctr_we;
    logic             tgt_we;
    logic [1:0]       ctr_nxt;

    assign up_idx  = bp.ex_pc[IDX_W+1:2];
    assign up_tag  = bp.ex_pc[31:IDX_W+2];
    assign up_hit  = valid_q[up_idx] && (tag_mem[up_idx] == up_tag);
    // Conditional branches only allocate on a taken miss; everything else always allocates.
    assign alloc   = upd_en && (upd_kind != K_COND || (!up_hit && bp.ex_taken));
    assign hit_upd = upd_en && upd_kind == K_COND && up_hit;
    assign ctr_we  = alloc || hit_upd;
    assign tgt_we  = alloc || (hit_upd && bp.ex_taken);

    always_comb begin
        ctr_nxt = ctr_mem[up_idx];
        if (alloc)
            ctr_nxt = (upd_kind == K_COND) ? sat_inc(CTR_INIT) : 2'b11;
        else if (hit_upd)
            ctr_nxt = bp.ex_taken ? sat_inc(ctr_mem[up_idx]) : sat_dec(ctr_mem[up_idx]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_mem[i] <= CTR_INIT;
        end else begin
            if (alloc)  valid_q[up_idx] <= 1'b1;
            if (ctr_we) ctr_mem[up_idx] <= ctr_nxt;
        end
    end

    // NOTE: tag/target/kind storage is deliberately not reset; the valid bits
    // gate every use, so clearing the payload would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (alloc) begin
            tag_mem[up_idx]  <= up_tag;
            kind_mem[up_idx] <= upd_kind;
        end
        if (tgt_we) tgt_mem[up_idx] <= bp.ex_target;
    end

    // ---------------- Return-address stack ----------------
    logic             pop_ok;
    logic [RAS_W-1:0] ptr_mid;
    logic [CNT_W-1:0] cnt_mid;
    logic [31:0]      link_pc;

    // A pop is applied before a push, so JALR $31 replaces the top in place.
    assign pop_ok  = pop_req && ras_cnt != '0;
    assign ptr_mid = pop_ok ? ras_ptr - RAS_W'(1) : ras_ptr;
    assign cnt_mid = ras_cnt - CNT_W'(pop_ok);
    assign link_pc = bp.ex_pc + 32'd8;

    always_ff @(posedge clk) begin
        if (rst) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (push_req) begin
            ras_ptr <= ptr_mid + RAS_W'(1);
            ras_cnt <= (cnt_mid == RAS_FULL) ? cnt_mid : cnt_mid + CNT_W'(1);
        end else begin
            ras_ptr <= ptr_mid;
            ras_cnt <= cnt_mid;
        end
    end

    always_ff @(posedge clk) begin
        if (push_req) ras_mem[ptr_mid] <= link_pc;
    end

    // ---------------- Mispredict detection ----------------
    logic mp_cond;

    assign mp_cond = upd_en && ((bp.ex_taken != bp.ex_pred_taken) ||
                                (bp.ex_taken && bp.ex_target != bp.ex_pred_target));

    always_ff @(posedge clk) begin
        if (rst) begin
            bp.mispredict  <= 1'b0;
            bp.redirect_pc <= '0;
        end else begin
            bp.mispredict <= mp_cond;
            if (mp_cond) bp.redirect_pc <= bp.ex_taken ? bp.ex_target : link_pc;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random traffic,
// checked every cycle against a table/queue reference model.
module tb_branch_predictor;
    localparam int         ENTRIES   = 16;
    localparam int         RAS_DEPTH = 4;
    localparam logic [1:0] CTR_INIT  = 2'b01;

    localparam bit [3:0] T_BEQ = 4'd1,  T_BNE = 4'd2,  T_BGEZ = 4'd3,  T_BGTZ = 4'd4,
                         T_BLEZ = 4'd5, T_BLTZ = 4'd6, T_BGEZAL = 4'd7, T_BLTZAL = 4'd8,
                         T_J = 4'd9,    T_JAL = 4'd10, T_JR = 4'd11,    T_JALR = 4'd12;
    localparam int K_COND = 0, K_JUMP = 1, K_CALL = 2, K_RET = 3;

    typedef struct {
        bit        v;
        bit [3:0]  typ;
        bit [31:0] pc;
        bit        ra;
        bit        taken;
        bit [31:0] tgt;
        bit        ptaken;
        bit [31:0] ptgt;
    } ex_t;

    typedef struct {
        bit        valid;
        bit [31:0] pc;
        bit [31:0] target;
        int        kind;
        int        ctr;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    ent_t      btb [ENTRIES];
    bit [31:0] ras_q[$];

    always #5 clk = ~clk;

    branch_predictor_if bp ();

    branch_predictor #(
        .ENTRIES  (ENTRIES),
        .RAS_DEPTH(RAS_DEPTH),
        .CTR_INIT (CTR_INIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bp (bp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int kind_of(input bit [3:0] typ, input bit ra);
        case (typ)
            T_BEQ, T_BNE, T_BGEZ, T_BGTZ, T_BLEZ, T_BLTZ, T_BGEZAL, T_BLTZAL: return K_COND;
            T_J:           return K_JUMP;
            T_JAL, T_JALR: return K_CALL;
            T_JR:          return ra ? K_RET : K_JUMP;
            default:       return -1;
        endcase
    endfunction

    function automatic int idx_of(input bit [31:0] pc);
        return int'(pc[31:2] % 30'(ENTRIES));
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            btb[i].valid = 1'b0;
            btb[i].ctr   = int'(CTR_INIT);
        end
        ras_q.delete();
    endfunction

    function automatic void model_lookup(input bit [31:0] pc, output bit taken, output bit [31:0] tgt);
        int i = idx_of(pc);
        bit hit = btb[i].valid && btb[i].pc[31:2] == pc[31:2];
        taken = hit && (btb[i].kind != K_COND || btb[i].ctr >= 2);
        tgt = 32'h0;
        if (taken) tgt = (btb[i].kind == K_RET && ras_q.size() > 0) ? ras_q[$] : btb[i].target;
    endfunction

    function automatic void model_update(input ex_t ex);
        int  k = kind_of(ex.typ, ex.ra);
        int  i = idx_of(ex.pc);
        bit  hit = btb[i].valid && btb[i].pc[31:2] == ex.pc[31:2];
        bit  pop, push;
        if (!ex.v || k < 0) return;
        if (k == K_COND) begin
            if (hit) begin
                btb[i].ctr = ex.taken ? ((btb[i].ctr == 3) ? 3 : btb[i].ctr + 1)
                                      : ((btb[i].ctr == 0) ? 0 : btb[i].ctr - 1);
                if (ex.taken) btb[i].target = ex.tgt;
            end else if (ex.taken) begin
                btb[i] = '{1'b1, ex.pc, ex.tgt, K_COND, (int'(CTR_INIT) == 3) ? 3 : int'(CTR_INIT) + 1};
            end
        end else begin
            btb[i] = '{1'b1, ex.pc, ex.tgt, k, 3};
        end
        pop  = ex.ra && (ex.typ == T_JR || ex.typ == T_JALR);
        push = ex.typ == T_JAL || ex.typ == T_JALR ||
               ((ex.typ == T_BGEZAL || ex.typ == T_BLTZAL) && ex.taken);
        if (pop && ras_q.size() > 0) void'(ras_q.pop_back());
        if (push) begin
            if (ras_q.size() == RAS_DEPTH) void'(ras_q.pop_front());
            ras_q.push_back(ex.pc + 32'd8);
        end
    endfunction

    function automatic ex_t mk(input bit [3:0] typ, input bit [31:0] pc, input bit taken,
                               input bit [31:0] tgt, input bit ptaken, input bit [31:0] ptgt,
                               input bit ra);
        ex_t e;
        e = '{1'b1, typ, pc, ra, taken, tgt, ptaken, ptgt};
        return e;
    endfunction

    function automatic ex_t none();
        ex_t e;
        e = '{1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        return e;
    endfunction

    // One clock: drive, predict from the model, advance, compare.
    task automatic cycle(input bit iv, input bit [31:0] ipc, input ex_t ex);
        bit        ept;
        bit [31:0] etg;
        bit        emp;
        bit [31:0] erd;
        int        k;
        bp.if_valid       = iv;
        bp.if_pc          = ipc;
        bp.ex_valid       = ex.v;
        bp.ex_pc          = ex.pc;
        bp.ex_type        = ex.typ;
        bp.ex_rs_is_ra    = ex.ra;
        bp.ex_taken       = ex.taken;
        bp.ex_target      = ex.tgt;
        bp.ex_pred_taken  = ex.ptaken;
        bp.ex_pred_target = ex.ptgt;
        model_lookup(ipc, ept, etg);
        if (!iv || rst) begin
            ept = 1'b0;
            etg = 32'h0;
        end
        k   = kind_of(ex.typ, ex.ra);
        emp = !rst && ex.v && k >= 0 &&
              (ex.taken != ex.ptaken || (ex.taken && ex.tgt != ex.ptgt));
        erd = ex.taken ? ex.tgt : ex.pc + 32'd8;
        if (rst) model_reset();
        else model_update(ex);
        @(posedge clk);
        #1;
        check("pred_valid", 32'(bp.pred_valid), 32'(iv && !rst));
        check("pred_taken", 32'(bp.pred_taken), 32'(ept));
        check("pred_target", bp.pred_target, etg);
        check("mispredict", 32'(bp.mispredict), 32'(emp));
        if (emp) check("redirect_pc", bp.redirect_pc, erd);
    endtask

    task automatic expect_pred(input string tag, input bit taken, input bit [31:0] tgt);
        check({tag, "_taken"}, 32'(bp.pred_taken), 32'(taken));
        check({tag, "_target"}, bp.pred_target, tgt);
    endtask

    initial begin
        bit [31:0] ret_pc;
        model_reset();
        cycle(1'b0, 32'h0, none());

        // Resolve in the reset cycle must not produce a pulse.
        cycle(1'b1, 32'h00400000, mk(T_BEQ, 32'h00400010, 1'b1, 32'h00400040, 1'b0, 32'h0, 1'b0));
        check("tp_reset_mispredict", 32'(bp.mispredict), 32'd0);
        rst = 1'b0;

        cycle(1'b1, 32'h00400000, none());
        check("tp_first_pred_valid", 32'(bp.pred_valid), 32'd1);
        expect_pred("tp_first", 1'b0, 32'h0);

        // Counter walk for BEQ at 0x00400010.
        cycle(1'b0, 32'h0, mk(T_BEQ, 32'h00400010, 1'b1, 32'h00400040, 1'b0, 32'h0, 1'b0));
        check("tp_beq_mispredict", 32'(bp.mispredict), 32'd1);
        check("tp_beq_redirect", bp.redirect_pc, 32'h00400040);
        cycle(1'b1, 32'h00400010, none());
        expect_pred("tp_beq_ctr10", 1'b1, 32'h00400040);
        cycle(1'b0, 32'h0, mk(T_BEQ, 32'h00400010, 1'b1, 32'h00400040, 1'b1, 32'h00400040, 1'b0));
        for (int n = 0; n < 3; n++) begin
            cycle(1'b0, 32'h0, mk(T_BEQ, 32'h00400010, 1'b0, 32'h00400040, 1'b1, 32'h00400040, 1'b0));
            check("tp_nt_redirect", bp.redirect_pc, 32'h00400018);
        end
        cycle(1'b1, 32'h00400010, none());
        expect_pred("tp_beq_ctr00", 1'b0, 32'h0);
        cycle(1'b0, 32'h0, mk(T_BEQ, 32'h00400010, 1'b0, 32'h00400040, 1'b0, 32'h0, 1'b0));
        check("tp_nt_no_mispredict", 32'(bp.mispredict), 32'd0);
        cycle(1'b1, 32'h00400010, none());
        expect_pred("tp_beq_sat00", 1'b0, 32'h0);

        // Call/return through the RAS.
        cycle(1'b0, 32'h0, mk(T_JAL, 32'h00400100, 1'b1, 32'h00500000, 1'b1, 32'h00500000, 1'b0));
        cycle(1'b0, 32'h0, mk(T_JR, 32'h00400200, 1'b1, 32'h00400108, 1'b1, 32'h00400108, 1'b1));
        cycle(1'b1, 32'h00400200, none());
        expect_pred("tp_ret_empty", 1'b1, 32'h00400108);
        cycle(1'b0, 32'h0, mk(T_JAL, 32'h00400304, 1'b1, 32'h00500000, 1'b1, 32'h00500000, 1'b0));
        cycle(1'b1, 32'h00400200, none());
        expect_pred("tp_ret_ras", 1'b1, 32'h0040030C);
        cycle(1'b0, 32'h0, mk(T_JR, 32'h00400200, 1'b1, 32'h00400108, 1'b1, 32'h0040030C, 1'b1));
        cycle(1'b1, 32'h00400200, none());
        expect_pred("tp_ret_popped", 1'b1, 32'h00400108);

        // RAS overflow then drain, returning from 0x00400244.
        ret_pc = 32'h00400244;
        cycle(1'b0, 32'h0, mk(T_JR, ret_pc, 1'b1, 32'h00400108, 1'b1, 32'h00400108, 1'b1));
        for (int n = 1; n <= RAS_DEPTH + 1; n++)
            cycle(1'b0, 32'h0, mk(T_JAL, 32'(n) << 12, 1'b1, 32'h00600000, 1'b1, 32'h00600000, 1'b0));
        for (int n = 0; n < RAS_DEPTH; n++) begin
            cycle(1'b1, ret_pc, mk(T_JR, ret_pc, 1'b1, 32'h00400108, 1'b1, 32'h00400108, 1'b1));
            expect_pred("tp_ras_drain", 1'b1, (32'(RAS_DEPTH + 1 - n) << 12) + 32'd8);
        end
        cycle(1'b1, ret_pc, mk(T_JR, ret_pc, 1'b1, 32'h00400108, 1'b1, 32'h00400108, 1'b1));
        expect_pred("tp_ras_empty", 1'b1, 32'h00400108);
        cycle(1'b1, ret_pc, none());
        expect_pred("tp_ras_empty2", 1'b1, 32'h00400108);

        // Aliasing: A and B share an index.
        cycle(1'b0, 32'h0, mk(T_BEQ, 32'h00400060, 1'b1, 32'h00400800, 1'b0, 32'h0, 1'b0));
        cycle(1'b0, 32'h0, mk(T_J, 32'h004000A0, 1'b1, 32'h00400900, 1'b1, 32'h00400900, 1'b0));
        cycle(1'b1, 32'h00400060, none());
        expect_pred("tp_alias_evicted", 1'b0, 32'h0);
        cycle(1'b1, 32'h004000A0, none());
        expect_pred("tp_alias_new", 1'b1, 32'h00400900);
        cycle(1'b1, 32'h004000A0, mk(T_J, 32'h00400060, 1'b1, 32'h00400A00, 1'b1, 32'h00400A00, 1'b0));
        expect_pred("tp_rbw", 1'b1, 32'h00400900);
        cycle(1'b1, 32'h004000A0, none());
        expect_pred("tp_rbw_after", 1'b0, 32'h0);

        // Link/fall-through address wraps at 2^32.
        cycle(1'b0, 32'h0, mk(T_BEQ, 32'hFFFFFFFC, 1'b0, 32'h0, 1'b1, 32'h00001000, 1'b0));
        check("tp_wrap_redirect", bp.redirect_pc, 32'h00000004);

        for (int n = 0; n < 600; n++) begin
            ex_t       ex;
            bit [31:0] ipc;
            ipc       = 32'h00400000 + 32'($urandom_range(0, 39)) * 4;
            ex.v      = $urandom_range(0, 3) != 0;
            ex.typ    = 4'($urandom_range(0, 13));
            ex.pc     = 32'h00400000 + 32'($urandom_range(0, 39)) * 4;
            ex.ra     = 1'($urandom_range(0, 1));
            ex.taken  = (ex.typ >= T_J && ex.typ <= T_JALR) ? 1'b1 : 1'($urandom_range(0, 1));
            ex.tgt    = 32'h00400000 + 32'($urandom_range(0, 255)) * 4;
            ex.ptaken = 1'($urandom_range(0, 1));
            ex.ptgt   = ($urandom_range(0, 1) != 0) ? ex.tgt
                                                    : 32'h00400000 + 32'($urandom_range(0, 255)) * 4;
            cycle($urandom_range(0, 3) != 0, ipc, ex);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
